trig_coinc_gen: RTL and testbench

- Parametrised next-generation trigger coincidence generator for the SCROD readout chain.
- Each masked ACK line is stretched over a programmable coincidence window, and the active lines are counted.
- A trigger is issued to all N_CH outputs when the count reaches a threshold, or when a software trigger edge arrives.
- The trigger is held for a programmable, retriggerable number of cycles; the block keeps a saturating trigger counter and optional per-channel hit counters.

---
 rtl/trig_coinc_gen.sv | 169 ++++++++++++++++
 tb/tb_trig_coinc_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/trig_coinc_gen.sv
// trig_coinc_gen: stretched-ACK coincidence trigger with soft trigger, retriggerable hold and statistics.
// Define TRIG_CHAN_COUNT_EN to build the per-channel 16-bit hit counters on CHAN_STATISTICS.
//
// state | meaning
// IDLE  | waiting for a hardware or software hit
// FIRE  | first trigger cycle, statistics already counted
// HOLD  | trigger held; a hit reloads hold_cnt
module trig_coinc_gen #(
  parameter int N_CH   = 12,
  parameter int SEL_W  = 4,
  parameter int WIN_W  = 3,
  parameter int HOLD_W = 3,
  parameter int CNT_W  = 32
) (
  input  logic                 CLK_42MHZ,
  input  logic                 RESET,
  input  logic [N_CH-1:0]      ACK,
  input  logic [N_CH-1:0]      TRG_MASK,
  input  logic [SEL_W-1:0]     MIN_SCRODS_REQUIRED,
  input  logic [WIN_W-1:0]     WINDOW,
  input  logic [HOLD_W-1:0]    HOLD_CYCLES,
  input  logic                 TRG_SOFT,
  output logic [N_CH-1:0]      TRG,
  output logic                 TRG_BUSY,
  output logic [CNT_W-1:0]     TRG_STATISTICS,
  output logic [N_CH*16-1:0]   CHAN_STATISTICS
);

  typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;

  logic [N_CH-1:0]   ack_m;
  logic [N_CH-1:0]   active_q;
  logic [WIN_W-1:0]  str_cnt [N_CH];
  logic [SEL_W-1:0]  pop;
  logic [SEL_W-1:0]  count_q;
  logic              hw_hit;
  logic              soft_s1, soft_s2, soft_prev, soft_hit_q;
  logic [1:0]        soft_arm_q;
  logic              hit;
  state_t            state_q;
  logic [HOLD_W-1:0] hold_cnt;

  assign ack_m = ACK & TRG_MASK;

  always_ff @(posedge CLK_42MHZ) begin
    if (RESET) begin
      active_q <= '0;
      for (int i = 0; i < N_CH; i++) str_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ack_m[i]) begin
          active_q[i] <= 1'b1;
          str_cnt[i]  <= WINDOW;
        end else if (str_cnt[i] != '0) begin
          active_q[i] <= 1'b1;
          str_cnt[i]  <= str_cnt[i] - 1'b1;
        end else begin
          active_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) pop = pop + SEL_W'(active_q[i]);
  end

  always_ff @(posedge CLK_42MHZ) begin
    if (RESET) count_q <= '0;
    else       count_q <= pop;
  end

  assign hw_hit = (MIN_SCRODS_REQUIRED != '0) && (count_q >= MIN_SCRODS_REQUIRED);

  // The synchroniser restarts from 0, so the edge detector is held "high" until
  // both stages carry real samples; a level held through reset then never fires.
  always_ff @(posedge CLK_42MHZ) begin
    if (RESET) begin
      soft_s1    <= 1'b0;
      soft_s2    <= 1'b0;
      soft_prev  <= 1'b1;
      soft_hit_q <= 1'b0;
      soft_arm_q <= 2'b00;
    end else begin
      soft_s1    <= TRG_SOFT;
      soft_s2    <= soft_s1;
      soft_arm_q <= {soft_arm_q[0], 1'b1};
      soft_prev  <= soft_arm_q[1] ? soft_s2 : 1'b1;
      soft_hit_q <= soft_s2 & ~soft_prev;
    end
  end

  assign hit = hw_hit | soft_hit_q;

  always_ff @(posedge CLK_42MHZ) begin
    if (RESET) begin
      state_q        <= IDLE;
      hold_cnt       <= '0;
      TRG            <= '0;
      TRG_BUSY       <= 1'b0;
      TRG_STATISTICS <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            state_q  <= FIRE;
            TRG      <= '1;
            TRG_BUSY <= 1'b1;
            if (TRG_STATISTICS != '1) TRG_STATISTICS <= TRG_STATISTICS + 1'b1;
          end
        end
        FIRE: begin
          if (HOLD_CYCLES == '0 && !hit) begin
            state_q  <= IDLE;
            TRG      <= '0;
            TRG_BUSY <= 1'b0;
          end else begin
            state_q  <= HOLD;
            hold_cnt <= HOLD_CYCLES;
          end
        end
        HOLD: begin
          if (hit) begin
            hold_cnt <= HOLD_CYCLES;
          end else if (hold_cnt <= HOLD_W'(1)) begin
            // also covers a zero reload from a retrigger with HOLD_CYCLES=0
            state_q  <= IDLE;
            TRG      <= '0;
            TRG_BUSY <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          TRG      <= '0;
          TRG_BUSY <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRIG_CHAN_COUNT_EN
  logic [N_CH-1:0] ack_m_q;
  logic [15:0]     chan_cnt [N_CH];

  always_ff @(posedge CLK_42MHZ) begin
    if (RESET) begin
      ack_m_q <= '0;
      for (int i = 0; i < N_CH; i++) chan_cnt[i] <= '0;
    end else begin
      ack_m_q <= ack_m;
      for (int i = 0; i < N_CH; i++) begin
        if (ack_m[i] && !ack_m_q[i] && chan_cnt[i] != 16'hFFFF)
          chan_cnt[i] <= chan_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    CHAN_STATISTICS = '0;
    for (int i = 0; i < N_CH; i++) CHAN_STATISTICS[16*i +: 16] = chan_cnt[i];
  end
`else
  assign CHAN_STATISTICS = '0;
`endif

endmodule

// File: tb/tb_trig_coinc_gen.sv
// Directed bench for trig_coinc_gen: cycle vector table plus hand-written soft/reset/saturation sequences.
module tb_trig_coinc_gen;

  logic          CLK_42MHZ = 1'b0;
  logic          RESET;
  logic [11:0]   ACK;
  logic [11:0]   TRG_MASK;
  logic [3:0]    MIN_SCRODS_REQUIRED;
  logic [2:0]    WINDOW;
  logic [2:0]    HOLD_CYCLES;
  logic          TRG_SOFT;
  logic [11:0]   TRG;
  logic          TRG_BUSY;
  logic [31:0]   TRG_STATISTICS;
  logic [191:0]  CHAN_STATISTICS;
  logic [11:0]   trg_s;
  logic          busy_s;
  logic [3:0]    stat_s;
  logic [191:0]  chan_s;

  int total = 0;
  int bad   = 0;

  always #12 CLK_42MHZ = ~CLK_42MHZ;

  trig_coinc_gen dut (
    .CLK_42MHZ(CLK_42MHZ), .RESET(RESET), .ACK(ACK), .TRG_MASK(TRG_MASK),
    .MIN_SCRODS_REQUIRED(MIN_SCRODS_REQUIRED), .WINDOW(WINDOW), .HOLD_CYCLES(HOLD_CYCLES),
    .TRG_SOFT(TRG_SOFT), .TRG(TRG), .TRG_BUSY(TRG_BUSY),
    .TRG_STATISTICS(TRG_STATISTICS), .CHAN_STATISTICS(CHAN_STATISTICS)
  );

  trig_coinc_gen #(.CNT_W(4)) dut_sat (
    .CLK_42MHZ(CLK_42MHZ), .RESET(RESET), .ACK(ACK), .TRG_MASK(TRG_MASK),
    .MIN_SCRODS_REQUIRED(MIN_SCRODS_REQUIRED), .WINDOW(WINDOW), .HOLD_CYCLES(HOLD_CYCLES),
    .TRG_SOFT(TRG_SOFT), .TRG(trg_s), .TRG_BUSY(busy_s),
    .TRG_STATISTICS(stat_s), .CHAN_STATISTICS(chan_s)
  );

  typedef struct {
    logic [11:0] ack;
    logic [11:0] mask;
    logic [3:0]  min;
    logic [2:0]  win;
    logic [2:0]  hold;
    logic [11:0] exp_trg;
  } vec_t;

  vec_t vecs[$];

  task automatic add_n(input int n, input logic [11:0] ack, input logic [11:0] mask,
                       input logic [3:0] min, input logic [2:0] win, input logic [2:0] hold,
                       input logic [11:0] exp_trg);
    vec_t v;
    v.ack = ack; v.mask = mask; v.min = min; v.win = win; v.hold = hold; v.exp_trg = exp_trg;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_42MHZ);
    #1;
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [191:0] exp_chan;

    RESET = 1'b1; ACK = '0; TRG_MASK = 12'hFFF; MIN_SCRODS_REQUIRED = 4'd2;
    WINDOW = '0; HOLD_CYCLES = 3'd7; TRG_SOFT = 1'b0;
    step(); step();
    RESET = 1'b0;

    check("rst_trg",   TRG, 0);
    check("rst_busy",  TRG_BUSY, 0);
    check("rst_stat",  TRG_STATISTICS, 0);
    check("rst_chan",  CHAN_STATISTICS, 0);
    check("rst_stat4", stat_s, 0);

    // isolated 2-channel hit, hold 7 -> 8 trigger cycles starting after edge k+2
    add_n(1, 12'h003, 12'hFFF, 2, 0, 7, 12'h000);
    add_n(1, 12'h000, 12'hFFF, 2, 0, 7, 12'h000);
    add_n(8, 12'h000, 12'hFFF, 2, 0, 7, 12'hFFF);
    add_n(1, 12'h000, 12'hFFF, 2, 0, 7, 12'h000);
    // window 3: ACK[5] at k+3 overlaps the stretched ACK[0]
    add_n(1, 12'h001, 12'hFFF, 2, 3, 0, 12'h000);
    add_n(2, 12'h000, 12'hFFF, 2, 3, 0, 12'h000);
    add_n(1, 12'h020, 12'hFFF, 2, 3, 0, 12'h000);
    add_n(1, 12'h000, 12'hFFF, 2, 3, 0, 12'h000);
    add_n(1, 12'h000, 12'hFFF, 2, 3, 0, 12'hFFF);
    add_n(3, 12'h000, 12'hFFF, 2, 3, 0, 12'h000);
    // ACK[5] at k+4 lands just after the stretch ends
    add_n(1, 12'h001, 12'hFFF, 2, 3, 0, 12'h000);
    add_n(3, 12'h000, 12'hFFF, 2, 3, 0, 12'h000);
    add_n(1, 12'h020, 12'hFFF, 2, 3, 0, 12'h000);
    add_n(5, 12'h000, 12'hFFF, 2, 3, 0, 12'h000);
    // masked-out channels, then threshold 0 disables hardware trigger
    add_n(5, 12'hFF0, 12'h00F, 3, 0, 0, 12'h000);
    add_n(5, 12'hFFF, 12'hFFF, 0, 0, 0, 12'h000);
    add_n(3, 12'h000, 12'hFFF, 0, 0, 0, 12'h000);
    // sustained hits with hold 2: one trigger, stays high until hits drain
    add_n(2,  12'hFFF, 12'hFFF, 2, 0, 2, 12'h000);
    add_n(18, 12'hFFF, 12'hFFF, 2, 0, 2, 12'hFFF);
    add_n(3,  12'h000, 12'hFFF, 2, 0, 2, 12'hFFF);
    add_n(3,  12'h000, 12'hFFF, 2, 0, 2, 12'h000);

    foreach (vecs[i]) begin
      ACK = vecs[i].ack; TRG_MASK = vecs[i].mask; MIN_SCRODS_REQUIRED = vecs[i].min;
      WINDOW = vecs[i].win; HOLD_CYCLES = vecs[i].hold;
      step();
      check($sformatf("vec%0d_trg", i), TRG, vecs[i].exp_trg);
      check($sformatf("vec%0d_busy", i), TRG_BUSY, (vecs[i].exp_trg != 0));
    end
    check("table_stat", TRG_STATISTICS, 3);

    // hardware and soft hit landing in the same cycle count once
    MIN_SCRODS_REQUIRED = 4'd2; HOLD_CYCLES = 3'd1; WINDOW = '0; TRG_MASK = 12'hFFF;
    TRG_SOFT = 1'b1;
    step();
    ACK = 12'h003;
    step();
    ACK = 12'h000;
    step(); check("sim_pre",  TRG, 12'h000);
    step(); check("sim_fire", TRG, 12'hFFF);
    step(); check("sim_hold", TRG, 12'hFFF);
    step(); check("sim_end",  TRG, 12'h000);
    check("sim_stat", TRG_STATISTICS, 4);
    TRG_SOFT = 1'b0;
    step(); step(); step();

    // asynchronous soft trigger with hardware path disabled
    MIN_SCRODS_REQUIRED = 4'd0;
    #5 TRG_SOFT = 1'b1;
    lat = 0;
    while (TRG == 12'h000 && lat < 8) begin
      step();
      lat++;
    end
    check("soft_lat_ok", (lat >= 3 && lat <= 4), 1);
    step(); check("soft_hold", TRG, 12'hFFF);
    step(); check("soft_end",  TRG, 12'h000);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("soft_level%0d", i), TRG, 12'h000);
    end
    check("soft_stat", TRG_STATISTICS, 5);
    TRG_SOFT = 1'b0;
    step(); step(); step();

    // reset in the middle of a trigger drops it on the same edge
    MIN_SCRODS_REQUIRED = 4'd2; HOLD_CYCLES = 3'd7;
    ACK = 12'h003;
    step();
    ACK = 12'h000;
    step(); step();
    check("mid_trg_on", TRG, 12'hFFF);
    step();
    RESET = 1'b1;
    step();
    check("mid_rst_trg",  TRG, 12'h000);
    check("mid_rst_busy", TRG_BUSY, 0);
    check("mid_rst_stat", TRG_STATISTICS, 0);
    RESET = 1'b0;
    step(); step();

    // soft level held across reset must not trigger afterwards
    TRG_SOFT = 1'b1;
    step(); step();
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("soft_rst%0d", i), TRG, 12'h000);
    end
    check("soft_rst_stat", TRG_STATISTICS, 0);
    TRG_SOFT = 1'b0;
    step(); step(); step();

    // 17 isolated triggers: 32-bit counter keeps counting, 4-bit build saturates
    MIN_SCRODS_REQUIRED = 4'd2; HOLD_CYCLES = 3'd0; WINDOW = '0;
    for (int t = 0; t < 17; t++) begin
      ACK = 12'h003;
      step();
      ACK = 12'h000;
      step(); step(); step(); step();
      if (t == 14) check("sat_15", stat_s, 4'hF);
    end
    check("sat_full",  stat_s, 4'hF);
    check("sat_count", TRG_STATISTICS, 17);

    // channel counters: 5 rising edges on ACK[3] of varying widths, ACK[4] masked
    pulse_reset();
    MIN_SCRODS_REQUIRED = 4'd0; TRG_MASK = 12'hFEF;
    for (int p = 0; p < 5; p++) begin
      int w;
      w = (p == 1) ? 2 : (p == 3) ? 3 : 1;
      ACK = 12'h018;
      for (int c = 0; c < w; c++) step();
      ACK = 12'h000;
      step(); step();
    end
`ifdef TRIG_CHAN_COUNT_EN
    exp_chan = 192'd5 << 48;
`else
    exp_chan = '0;
`endif
    check("chan_stats",     CHAN_STATISTICS, exp_chan);
    check("chan_stats_sat", chan_s, exp_chan);
    check("chan_no_trg",    TRG_STATISTICS, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
